// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (default XGA 1024x768@60) gated by a synchronised PLL lock.
//   clk          pixel clock
//   rst          asynchronous active-high reset
//   locked       PLL lock flag, asynchronous to clk
//   hsync/vsync  sync pulses, active level SYNC_POL
//   de           pixel (pixel_x,pixel_y) lies in the visible area
//   pixel_x/y    raster position
//   frame_start  one-cycle pulse at pixel (0,0)
//   running      raster active (synchronised lock)
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FRONT  = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BACK   = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FRONT  = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 29,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
  output logic             running
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CNT_W-1:0] HA   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VA   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS0  = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS1  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS0  = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS1  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VMAX = CNT_W'(V_TOTAL - 1);
  localparam logic SYNC_ON = (SYNC_POL != 0);
  logic [1:0] lock_sync;
  logic lock_s, adv, x_wrap;
  logic [CNT_W-1:0] nx_x, nx_y;
  assign lock_s = lock_sync[1];
  // Counting only continues while already running and still locked; the
  // first running cycle after lock (or any relock) always starts at (0,0).
  always_comb begin
    adv    = lock_s && running;
    x_wrap = pixel_x == HMAX;
    nx_x   = (!adv || x_wrap) ? '0 : pixel_x + 1'b1;
    nx_y   = !adv ? '0 : !x_wrap ? pixel_y : (pixel_y == VMAX) ? '0 : pixel_y + 1'b1;
  end
  // Outputs are decoded from the next counter values so they line up with
  // the registered pixel_x/pixel_y of the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync   <= '0;
      running     <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
    end else begin
      lock_sync   <= {lock_sync[0], locked};
      running     <= lock_s;
      pixel_x     <= nx_x;
      pixel_y     <= nx_y;
      de          <= lock_s && (nx_x < HA) && (nx_y < VA);
      frame_start <= lock_s && (nx_x == '0) && (nx_y == '0);
      hsync       <= (lock_s && nx_x >= HS0 && nx_x < HS1) ? SYNC_ON : ~SYNC_ON;
      vsync       <= (lock_s && nx_y >= VS0 && nx_y < VS1) ? SYNC_ON : ~SYNC_ON;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for a small-raster and a default XGA vga_timing_gen.
module tb_vga_timing_gen;
  typedef struct { int x, y, de, hs, vs, fs, run; } exp_t;
  localparam int HA[2] = '{8, 1024};
  localparam int HF[2] = '{2, 24};
  localparam int HW[2] = '{3, 136};
  localparam int HB[2] = '{1, 160};
  localparam int VA[2] = '{4, 768};
  localparam int VF[2] = '{1, 3};
  localparam int VW[2] = '{2, 6};
  localparam int VB[2] = '{1, 29};
  logic clk = 0;
  logic rst = 1;
  logic locked = 1;
  logic s_hs, s_vs, s_de, s_fs, s_run;
  logic [3:0] s_x, s_y;
  logic b_hs, b_vs, b_de, b_fs, b_run;
  logic [10:0] b_x, b_y;
  int n_checks = 0;
  int n_fail = 0;
  logic m_s0 = 0, m_s1 = 0, m_run = 0;
  int m_p[2] = '{0, 0};
  exp_t q0[$];
  exp_t q1[$];
  always #5 clk = ~clk;
  vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(0), .CNT_W(4)) u_s (
    .clk(clk), .rst(rst), .locked(locked), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs), .running(s_run));
  vga_timing_gen u_b (
    .clk(clk), .rst(rst), .locked(locked), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs), .running(b_run));
  task automatic chk(string tag, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, want, $time);
    end
  endtask
  function automatic int ht(int k);
    return HA[k] + HF[k] + HW[k] + HB[k];
  endfunction
  function automatic int vt(int k);
    return VA[k] + VF[k] + VW[k] + VB[k];
  endfunction
  // Expected outputs for a linear raster position p (0 = first pixel of a frame).
  function automatic exp_t expect_at(int k, int run, int p);
    exp_t e;
    e.run = run;
    e.x = run ? p % ht(k) : 0;
    e.y = run ? p / ht(k) : 0;
    e.de = (run != 0 && e.x < HA[k] && e.y < VA[k]) ? 1 : 0;
    e.hs = (run != 0 && e.x >= HA[k] + HF[k] && e.x < HA[k] + HF[k] + HW[k]) ? 0 : 1;
    e.vs = (run != 0 && e.y >= VA[k] + VF[k] && e.y < VA[k] + VF[k] + VW[k]) ? 0 : 1;
    e.fs = (run != 0 && p == 0) ? 1 : 0;
    return e;
  endfunction
  function automatic int next_p(int k);
    return (m_s1 && m_run) ? (m_p[k] + 1) % (ht(k) * vt(k)) : 0;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s0 <= 0;
      m_s1 <= 0;
      m_run <= 0;
      m_p <= '{0, 0};
      q0.delete();
      q1.delete();
    end else begin
      q0.push_back(expect_at(0, int'(m_s1), next_p(0)));
      q1.push_back(expect_at(1, int'(m_s1), next_p(1)));
      m_p[0] <= next_p(0);
      m_p[1] <= next_p(1);
      m_s0 <= locked;
      m_s1 <= m_s0;
      m_run <= m_s1;
    end
  end
  task automatic cmp(string p, exp_t e, int x, int y, int de, int hs, int vs, int fs, int run);
    chk({p, "x"}, x, e.x);
    chk({p, "y"}, y, e.y);
    chk({p, "de"}, de, e.de);
    chk({p, "hsync"}, hs, e.hs);
    chk({p, "vsync"}, vs, e.vs);
    chk({p, "frame_start"}, fs, e.fs);
    chk({p, "running"}, run, e.run);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (q0.size() == 0) chk("sb_s_empty", 0, 1);
      else cmp("s_", q0.pop_front(), int'(s_x), int'(s_y), int'(s_de), int'(s_hs), int'(s_vs), int'(s_fs), int'(s_run));
      if (q1.size() == 0) chk("sb_b_empty", 0, 1);
      else cmp("b_", q1.pop_front(), int'(b_x), int'(b_y), int'(b_de), int'(b_hs), int'(b_vs), int'(b_fs), int'(b_run));
    end
  end
  task automatic chk_reset(string p);
    chk({p, "s_run"}, int'(s_run), 0);
    chk({p, "s_x"}, int'(s_x), 0);
    chk({p, "s_y"}, int'(s_y), 0);
    chk({p, "s_hsync"}, int'(s_hs), 1);
    chk({p, "s_vsync"}, int'(s_vs), 1);
    chk({p, "b_run"}, int'(b_run), 0);
    chk({p, "b_de"}, int'(b_de), 0);
    chk({p, "b_fs"}, int'(b_fs), 0);
    chk({p, "b_x"}, int'(b_x), 0);
    chk({p, "b_hsync"}, int'(b_hs), 1);
  endtask
  task automatic chk_start(string p);
    chk({p, "_run0"}, int'(b_run), 0);
    @(negedge clk);
    chk({p, "_run1"}, int'(b_run), 0);
    @(negedge clk);
    chk({p, "_run"}, int'(b_run), 1);
    chk({p, "_x"}, int'(b_x), 0);
    chk({p, "_y"}, int'(b_y), 0);
    chk({p, "_de"}, int'(b_de), 1);
    chk({p, "_fs"}, int'(b_fs), 1);
    chk({p, "_s_fs"}, int'(s_fs), 1);
  endtask
  initial begin
    int n_de, n_hs, n_sfs, last_fs;
    repeat (3) @(negedge clk);
    chk_reset("rst_");
    #1 rst = 0;
    @(negedge clk);
    chk_start("t1");
    n_de = 0;
    n_hs = 0;
    n_sfs = 0;
    last_fs = -1;
    for (int i = 0; i < 1344; i++) begin
      if (i != 0) @(negedge clk);
      n_de += int'(b_de);
      n_hs += int'(!b_hs);
      if (s_fs) begin
        if (last_fs >= 0) chk("s_fs_period", i - last_fs, 112);
        last_fs = i;
        n_sfs++;
      end
    end
    chk("b_line_de_count", n_de, 1024);
    chk("b_line_hsync_count", n_hs, 136);
    chk("s_fs_count", n_sfs, 12);
    @(negedge clk);
    chk("b_line_wrap_x", int'(b_x), 0);
    chk("b_line_wrap_y", int'(b_y), 1);
    repeat (37) @(negedge clk);
    locked = 0;
    repeat (3) @(negedge clk);
    chk("t4_s_run", int'(s_run), 0);
    chk("t4_b_run", int'(b_run), 0);
    chk("t4_b_x", int'(b_x), 0);
    chk("t4_b_hsync", int'(b_hs), 1);
    repeat (10) @(negedge clk);
    locked = 1;
    @(negedge clk);
    chk_start("t4_relock");
    repeat (40) @(negedge clk);
    #2 rst = 1;
    #1 chk_reset("t5_");
    #1 rst = 0;
    @(negedge clk);
    chk_start("t5_resume");
    repeat (130) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
